// File: rtl/configurable_arbiter_n_input_1_output_pkg.sv
// Shared types for the N-input arbiter: arbitration policy and burst-lock state.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/configurable_arbiter_n_input_1_output_rr_priority_select.sv
// Purely combinational priority pick: first active request at or after base_ptr (base forced to 0 in fixed mode).
// Zero latency, no flow control; yields a one-hot grant plus its binary index.
module rr_priority_select
  import arb_pkg::*;
#(
  parameter int NUM_REQUESTS = 4,
  parameter int ID_WIDTH     = 2
) (
  input  logic [NUM_REQUESTS-1:0] reqs,
  input  logic [ID_WIDTH-1:0]     base_ptr,
  input  logic                    mode,
  output logic [NUM_REQUESTS-1:0] grant,
  output logic [ID_WIDTH-1:0]     grant_idx
);

  logic [ID_WIDTH-1:0]     base;
  logic [NUM_REQUESTS-1:0] rot;
  logic [NUM_REQUESTS-1:0] iso;

  always_comb begin
    base = (mode == ARB_RR) ? base_ptr : '0;
    // Rotate so base_ptr lands on bit 0, keep the lowest set bit, then rotate back.
    rot   = NUM_REQUESTS'({reqs, reqs} >> base);
    iso   = rot & (~rot + 1'b1);
    grant = NUM_REQUESTS'(({iso, iso} << base) >> NUM_REQUESTS);
    grant_idx = '0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      if (grant[i]) grant_idx = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/configurable_arbiter_n_input_1_output.sv
// N:1 arbiter (fixed or round-robin) with burst locking; request to registered output in 1 cycle.
// One-deep output register: a new beat loads only when empty or drained in the same cycle.
module configurable_arbiter_n_input_1_output
  import arb_pkg::*;
#(
  parameter int NUM_REQUESTS = 4,
  parameter int WIDTH        = 8,
  parameter int ID_WIDTH     = 2
) (
  input  logic                                clock,
  input  logic                                rstn,
  input  logic                                enabled,
  input  logic                                arb_mode,
  input  logic [NUM_REQUESTS-1:0][WIDTH-1:0]  buffer_in,
  input  logic [NUM_REQUESTS-1:0]             requests,
  input  logic [NUM_REQUESTS-1:0]             requests_last,
  output logic [WIDTH-1:0]                    arbiter_out,
  output logic                                arbiter_out_valid,
  output logic [ID_WIDTH-1:0]                 arbiter_out_id,
  output logic                                arbiter_out_last,
  input  logic                                arbiter_out_ready,
  output logic [NUM_REQUESTS-1:0]             ready
);

  arb_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]     owner_q, owner_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]        out_q;
  logic                    vld_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic                    last_q;

  logic [NUM_REQUESTS-1:0] sel_grant;
  logic [ID_WIDTH-1:0]     sel_idx;
  logic [NUM_REQUESTS-1:0] grant;
  logic [ID_WIDTH-1:0]     win_idx;
  logic                    win_last;
  logic                    can_load;
  logic                    take;

  rr_priority_select #(
    .NUM_REQUESTS (NUM_REQUESTS),
    .ID_WIDTH     (ID_WIDTH)
  ) u_select (
    .reqs      (requests),
    .base_ptr  (rr_ptr_q),
    .mode      (arb_mode),
    .grant     (sel_grant),
    .grant_idx (sel_idx)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    can_load = ~vld_q | arbiter_out_ready;
    // A locked burst bypasses the policy; an owner bubble simply stalls everyone.
    if (state_q == ARB_LOCKED) begin
      grant          = '0;
      grant[owner_q] = 1'b1;
      win_idx        = owner_q;
    end else begin
      grant   = sel_grant;
      win_idx = sel_idx;
    end
    ready    = (rstn && enabled && can_load) ? (grant & requests) : '0;
    take     = |ready;
    win_last = requests_last[win_idx];
    if (take) begin
      if (state_q == ARB_IDLE && !win_last) begin
        state_d = ARB_LOCKED;
        owner_d = win_idx;
      end else if (state_q == ARB_LOCKED && win_last) begin
        state_d = ARB_IDLE;
      end
      if (win_last && arb_mode == ARB_RR) begin
        rr_ptr_d = (win_idx == ID_WIDTH'(NUM_REQUESTS - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      id_q     <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      if (take) begin
        out_q  <= buffer_in[win_idx];
        id_q   <= win_idx;
        last_q <= win_last;
        vld_q  <= 1'b1;
      end else if (can_load) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign arbiter_out       = out_q;
  assign arbiter_out_valid = vld_q;
  assign arbiter_out_id    = id_q;
  assign arbiter_out_last  = last_q;

endmodule

// File: tb/tb_configurable_arbiter_n_input_1_output.sv
// Directed bench for the N:1 arbiter: behavioural grant model feeding a beat scoreboard.
module tb_configurable_arbiter_n_input_1_output;
  import arb_pkg::*;

  logic            clock = 1'b0;
  logic            rstn;
  logic            enabled;
  logic            arb_mode;
  logic [3:0][7:0] buffer_in;
  logic [3:0]      requests;
  logic [3:0]      requests_last;
  logic [7:0]      arbiter_out;
  logic            arbiter_out_valid;
  logic [1:0]      arbiter_out_id;
  logic            arbiter_out_last;
  logic            arbiter_out_ready;
  logic [3:0]      ready;

  always #5 clock = ~clock;

  configurable_arbiter_n_input_1_output #(
    .NUM_REQUESTS (4),
    .WIDTH        (8),
    .ID_WIDTH     (2)
  ) dut (
    .clock             (clock),
    .rstn              (rstn),
    .enabled           (enabled),
    .arb_mode          (arb_mode),
    .buffer_in         (buffer_in),
    .requests          (requests),
    .requests_last     (requests_last),
    .arbiter_out       (arbiter_out),
    .arbiter_out_valid (arbiter_out_valid),
    .arbiter_out_id    (arbiter_out_id),
    .arbiter_out_last  (arbiter_out_last),
    .arbiter_out_ready (arbiter_out_ready),
    .ready             (ready)
  );

  typedef struct packed {
    logic [7:0] dat;
    logic [1:0] id;
    logic       last;
  } beat_t;

  beat_t      sb_q[$];
  int         checks = 0;
  int         fails  = 0;
  int         beat_n = 0;
  logic       m_locked;
  logic [1:0] m_owner;
  logic [1:0] m_rr;
  logic       m_vld;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, advance the model past the edge.
  task automatic cyc(input logic rst, input logic en, input logic mode, input logic ordy,
                     input logic [3:0] req, input logic [3:0] lst);
    logic [3:0] exp_rdy;
    logic       found;
    logic [1:0] w;
    int         idx;
    beat_t      b;
    rstn              = rst;
    enabled           = en;
    arb_mode          = mode;
    arbiter_out_ready = ordy;
    requests          = req;
    requests_last     = lst;
    for (int i = 0; i < 4; i++) buffer_in[i] = {i[1:0], 6'(beat_n + 7 * i)};
    beat_n++;
    #1;
    found   = 1'b0;
    w       = 2'd0;
    exp_rdy = 4'b0000;
    if (rst && en && (!m_vld || ordy)) begin
      if (m_locked) begin
        if (req[m_owner]) begin
          found = 1'b1;
          w     = m_owner;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          idx = mode ? (int'(m_rr) + k) % 4 : k;
          if (!found && req[idx]) begin
            found = 1'b1;
            w     = 2'(idx);
          end
        end
      end
    end
    if (found) exp_rdy[w] = 1'b1;
    chk("ready", 16'(ready), 16'(exp_rdy));
    chk("valid", 16'(arbiter_out_valid), 16'(m_vld));
    if (m_vld) begin
      chk("sb_nonempty", 16'(sb_q.size() != 0), 16'd1);
      if (sb_q.size() != 0) begin
        b = sb_q[0];
        chk("beat", 16'({arbiter_out, arbiter_out_id, arbiter_out_last}), 16'(b));
        if (ordy) void'(sb_q.pop_front());
      end
    end
    if (!rst) begin
      m_locked = 1'b0;
      m_owner  = 2'd0;
      m_rr     = 2'd0;
      m_vld    = 1'b0;
      sb_q.delete();
    end else if (found) begin
      sb_q.push_back('{dat: buffer_in[w], id: w, last: lst[w]});
      m_vld = 1'b1;
      if (!m_locked && !lst[w]) begin
        m_locked = 1'b1;
        m_owner  = w;
      end else if (m_locked && lst[w]) begin
        m_locked = 1'b0;
      end
      if (lst[w] && mode) m_rr = w + 2'd1;
    end else if (!m_vld || ordy) begin
      m_vld = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    rstn              = 1'b0;
    enabled           = 1'b1;
    arb_mode          = ARB_FIXED;
    arbiter_out_ready = 1'b1;
    requests          = 4'b0000;
    requests_last     = 4'b1111;
    buffer_in         = '0;
    requests          = 4'b1111;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out", 16'({arbiter_out, arbiter_out_id, arbiter_out_last}), 16'd0);
    chk("reset_valid", 16'(arbiter_out_valid), 16'd0);
    chk("reset_ready", 16'(ready), 16'd0);
    m_locked = 1'b0;
    m_owner  = 2'd0;
    m_rr     = 2'd0;
    m_vld    = 1'b0;

    // Fixed priority: idx1 beats idx3 every cycle.
    repeat (5) cyc(1, 1, ARB_FIXED, 1, 4'b1010, 4'b1111);
    cyc(1, 1, ARB_FIXED, 1, 4'b0000, 4'b1111);

    // Round-robin across all four, six beats leaves the pointer at 2.
    repeat (6) cyc(1, 1, ARB_RR, 1, 4'b1111, 4'b1111);

    // idx2 three-beat burst while idx0/idx3 wait, then 3 and 0.
    cyc(1, 1, ARB_RR, 1, 4'b1101, 4'b1011);
    cyc(1, 1, ARB_RR, 1, 4'b1101, 4'b1011);
    cyc(1, 1, ARB_RR, 1, 4'b1101, 4'b1111);
    cyc(1, 1, ARB_RR, 1, 4'b1001, 4'b1111);
    cyc(1, 1, ARB_RR, 1, 4'b0001, 4'b1111);
    cyc(1, 1, ARB_RR, 1, 4'b0000, 4'b1111);

    // Backpressure: beat held and stable, then resumes.
    repeat (3) cyc(1, 1, ARB_FIXED, 0, 4'b0001, 4'b1111);
    repeat (2) cyc(1, 1, ARB_FIXED, 1, 4'b0001, 4'b1111);
    cyc(1, 1, ARB_FIXED, 1, 4'b0000, 4'b1111);

    // Disable mid-burst: drain, then owner keeps priority over idx0.
    cyc(1, 1, ARB_RR, 1, 4'b0011, 4'b0000);
    repeat (2) cyc(1, 0, ARB_RR, 1, 4'b0011, 4'b0000);
    cyc(1, 1, ARB_RR, 1, 4'b0011, 4'b0001);
    cyc(1, 1, ARB_RR, 1, 4'b0011, 4'b1111);
    cyc(1, 1, ARB_RR, 1, 4'b0000, 4'b1111);

    // Owner bubble stalls others, then reset drops the lock.
    cyc(1, 1, ARB_RR, 1, 4'b1000, 4'b0000);
    cyc(1, 1, ARB_RR, 1, 4'b0111, 4'b1111);
    cyc(0, 1, ARB_RR, 1, 4'b1111, 4'b0000);
    chk("rst_mid_out", 16'({arbiter_out, arbiter_out_id, arbiter_out_last}), 16'd0);
    cyc(1, 1, ARB_RR, 1, 4'b1010, 4'b1111);
    cyc(1, 1, ARB_RR, 1, 4'b1010, 4'b1111);
    repeat (2) cyc(1, 1, ARB_RR, 1, 4'b0000, 4'b1111);
    chk("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
